poly_mul_seq: RTL

Host-side initiator for the NTT/PWM/INTT engine controller. Accepts one polynomial-multiply command through a valid/ready handshake and drives the engine's `conf`/`start` inputs. A full multiply runs NTT(A), NTT(B), PWM and INTT in order; single operations are also supported. The block consumes the engine's `done` pulse, enforces a settle gap between operations, runs a watchdog on every operation, and returns a one-cycle response to the host.

---
 rtl/poly_seq_pkg.sv | 30 +++
 rtl/poly_mul_seq_if.sv | 23 ++
 rtl/seq_timer.sv | 17 +
 rtl/poly_mul_seq.sv | 74 +++++++
 4 files changed

// File: rtl/poly_seq_pkg.sv
// poly_seq_pkg: engine mode, command, operand-select and FSM state encodings for poly_mul_seq.
package poly_seq_pkg;
  localparam logic [2:0] CONF_NONE = 3'd0;
  localparam logic [2:0] CONF_NTT  = 3'd1;
  localparam logic [2:0] CONF_PWM  = 3'd2;
  localparam logic [2:0] CONF_INTT = 3'd3;
  localparam logic [1:0] OP_FULL = 2'd0;
  localparam logic [1:0] OP_NTT  = 2'd1;
  localparam logic [1:0] OP_PWM  = 2'd2;
  localparam logic [1:0] OP_INTT = 2'd3;
  localparam logic [1:0] SEL_A   = 2'd0;
  localparam logic [1:0] SEL_B   = 2'd1;
  localparam logic [1:0] SEL_AB  = 2'd2;
  localparam logic [1:0] SEL_RES = 2'd3;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;
  typedef struct packed {
    logic [2:0] conf;
    logic [1:0] sel;
  } stage_t;
  function automatic stage_t stage_of(logic [1:0] op, logic operand, logic [1:0] idx);
    return op == OP_NTT  ? stage_t'{CONF_NTT, {1'b0, operand}} :
           op == OP_PWM  ? stage_t'{CONF_PWM, SEL_AB} :
           op == OP_INTT ? stage_t'{CONF_INTT, SEL_RES} :
           stage_t'{idx == 2'd3 ? CONF_INTT : idx == 2'd2 ? CONF_PWM : CONF_NTT, idx};
  endfunction
endpackage

// File: rtl/poly_mul_seq_if.sv
// poly_mul_seq_if: host command/response and engine control signals of the multiply sequencer.
interface poly_mul_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_operand;
  logic [2:0] conf;
  logic       start;
  logic       done;
  logic [1:0] op_sel;
  logic [1:0] stage_idx;
  logic       busy;
  logic       rsp_valid;
  logic       rsp_err;
  modport slave (
    input  cmd_valid, cmd_op, cmd_operand, done,
    output cmd_ready, conf, start, op_sel, stage_idx, busy, rsp_valid, rsp_err
  );
  modport master (
    output cmd_valid, cmd_op, cmd_operand, done,
    input  cmd_ready, conf, start, op_sel, stage_idx, busy, rsp_valid, rsp_err
  );
endinterface

// File: rtl/seq_timer.sv
// seq_timer: saturating up-counter, held at zero while clr, with an equality hit against target.
module seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] target,
  output logic         hit
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (cnt != '1) cnt <= cnt + 1'b1;
  assign hit = cnt == target;
endmodule

// File: rtl/poly_mul_seq.sv
// poly_mul_seq: sequences NTT/PWM/INTT engine operations for one host command with settle gap and watchdog.
module poly_mul_seq #(
  parameter int GAP     = 2,
  parameter int TIMEOUT = 4096
) (
  input logic           clk,
  input logic           rst_n,
  poly_mul_seq_if.slave bus
);
  import poly_seq_pkg::*;
  localparam int WW = $clog2(TIMEOUT);
  localparam int GW = GAP < 1 ? 1 : $clog2(GAP + 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP > 0 ? GAP - 1 : 0);
  logic [2:0] state, nxt;
  logic [1:0] op;
  logic       operand, wd_hit, gap_hit, last, timeout, advance;
  stage_t     acc_st, nxt_st;
  assign last    = op != OP_FULL || bus.stage_idx == 2'd3;
  assign acc_st  = stage_of(bus.cmd_op, bus.cmd_operand, 2'd0);
  assign nxt_st  = stage_of(op, operand, bus.stage_idx + 2'd1);
  assign timeout = state == S_WAIT && !bus.done && wd_hit;
  assign advance = nxt == S_ISSUE && state != S_IDLE;
  seq_timer #(.W(WW)) u_wd (.clk(clk), .rst_n(rst_n), .clr(state != S_WAIT), .target(WD_LAST), .hit(wd_hit));
  seq_timer #(.W(GW)) u_gap (.clk(clk), .rst_n(rst_n), .clr(state != S_GAP), .target(GAP_LAST), .hit(gap_hit));
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = bus.cmd_valid ? S_ISSUE : S_IDLE;
      S_ISSUE: nxt = S_WAIT;
      S_WAIT:  nxt = bus.done ? (GAP > 0 ? S_GAP : last ? S_FINISH : S_ISSUE) : wd_hit ? S_FINISH : S_WAIT;
      S_GAP:   nxt = gap_hit ? (last ? S_FINISH : S_ISSUE) : S_GAP;
      default: nxt = S_IDLE;
    endcase
  end
  // Handshake outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      op            <= OP_FULL;
      operand       <= 1'b0;
      bus.conf      <= CONF_NONE;
      bus.op_sel    <= SEL_A;
      bus.stage_idx <= 2'd0;
      bus.start     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.cmd_ready <= 1'b1;
    end else begin
      state         <= nxt;
      bus.start     <= nxt == S_ISSUE;
      bus.busy      <= nxt != S_IDLE;
      bus.cmd_ready <= nxt == S_IDLE;
      bus.rsp_valid <= nxt == S_FINISH;
      bus.rsp_err   <= timeout;
      if (state == S_IDLE && bus.cmd_valid) begin
        op            <= bus.cmd_op;
        operand       <= bus.cmd_operand;
        bus.stage_idx <= 2'd0;
        bus.conf      <= acc_st.conf;
        bus.op_sel    <= acc_st.sel;
      end else if (advance) begin
        bus.stage_idx <= bus.stage_idx + 2'd1;
        bus.conf      <= nxt_st.conf;
        bus.op_sel    <= nxt_st.sel;
      end else if (state == S_FINISH) begin
        bus.stage_idx <= 2'd0;
        bus.conf      <= CONF_NONE;
        bus.op_sel    <= SEL_A;
      end
    end
  end
endmodule
